muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle signed 16-bit multiply/divide unit in the execute stage, beside the single-cycle ALU. Operand B comes from the same operand mux that carries sign-extended 4-bit immediates, so both operands are always treated as full 16-bit two's-complement values. Multiply returns a 32-bit product. Divide returns quotient and remainder. The control unit starts an operation with a one-cycle `start` pulse, holds the pipeline while `busy` is high, and writes back `result_lo` and `result_hi` (R0/R15 pair) on `done`.

## Interface
- `WIDTH`, 16, operand width; the result is 2*WIDTH wide, split into lo/hi halves.
- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `start`  in  1  one-cycle request; sampled only when not busy.
- `op`  in  1  0 = signed multiply, 1 = signed divide; latched with `start`.
- `a`  in  WIDTH  multiplicand or dividend, latched with `start`.
- `b`  in  WIDTH  multiplier or divisor, latched with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; results are valid from this cycle onward.
- `result_lo`  out  WIDTH  product[15:0] or quotient.
- `result_hi`  out  WIDTH  product[31:16] or remainder.
- `div_by_zero`  out  1  set together with `done` for a divide with b = 0; held until the next accepted start.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: 16 iterations, one per cycle, counted by a 4-bit counter.
  - FIX: sign correction.
  - DONE: one cycle.
- Transitions:
  - IDLE -> RUN on `start`, except a divide with b = 0.
  - IDLE -> DONE on `start` with op = 1 and b = 0.
  - RUN -> FIX when the counter reaches 15.
  - FIX -> DONE.
  - DONE -> RUN or DONE if `start` is high (same rules as IDLE); otherwise DONE -> IDLE.
- On accept: latch `op`, the magnitudes |a| and |b|, and the sign of each operand. Clear `div_by_zero`.
- Multiply: unsigned shift-add on the magnitudes, 16 iterations. FIX negates the 32-bit product when sign(a) XOR sign(b) = 1.
- Divide: unsigned restoring division on the magnitudes, 16 iterations. Quotient rounds toward zero and the remainder takes the sign of the dividend.
  - FIX negates the quotient when the operand signs differ.
  - FIX negates the remainder when a < 0.
- Width rules:
  - Magnitudes are held in 17 bits, so |−32768| = 32768 is represented exactly.
  - −32768 × −32768 = 0x4000_0000 (no overflow).
  - −32768 / −1 wraps: quotient 0x8000, remainder 0x0000. No flag is raised.
- Divide by zero: `result_lo` = 0x0000, `result_hi` = a (unchanged), `div_by_zero` = 1.
- `result_lo`/`result_hi` change only in the DONE cycle. They hold their value through IDLE and through a following operation until its DONE.
- `start` while busy (RUN or FIX) is ignored. It is not queued.
- Reset at any time, including mid-operation:
  - state -> IDLE;
  - `busy`, `done`, `div_by_zero` = 0;
  - `result_lo`, `result_hi` = 0x0000;
  - no `done` pulse is produced for the aborted operation.

## Timing
- Cycle 0 is the cycle in which `start` is high.
- Normal operation:
  - `busy` = 1 in cycles 1–17 (RUN 1–16, FIX 17).
  - `done` = 1 and `busy` = 0 in cycle 18.
  - Latency is 18 cycles, start to done.
- Divide by zero: `done` in cycle 1, `busy` never asserted.
- Back-to-back: `start` in the DONE cycle is accepted. Throughput is one operation per 18 cycles.
- All outputs are registered. No combinational path from inputs to outputs.
- `a`, `b` and `op` may change freely after cycle 0.

## Test plan
- Multiply: a = 0x0003, b = 0xFFFE, start -> cycle 18: `done` = 1, lo = 0xFFFA, hi = 0xFFFF, busy low. Check busy high in cycles 1–17 only.
- Signed divides, in sequence:
  - 7 / −2 -> lo = 0xFFFD, hi = 0x0001.
  - −7 / 2 -> lo = 0xFFFD, hi = 0xFFFF.
  - −7 / −2 -> lo = 0x0003, hi = 0xFFFF.
- Extremes:
  - 0x8000 × 0x8000 -> hi = 0x4000, lo = 0x0000.
  - 0x8000 / 0xFFFF -> lo = 0x8000, hi = 0x0000, `div_by_zero` = 0.
- Divide by zero: a = 0x0012, b = 0 -> cycle 1: `done` = 1, `div_by_zero` = 1, lo = 0x0000, hi = 0x0012. Next accepted start clears the flag.
- Start while busy: a 3 × 5 multiply with `start` re-pulsed in cycle 5 carrying 9 × 9 -> single `done` in cycle 18 with lo = 0x000F. Then a start in the DONE cycle is accepted, giving the next `done` 18 cycles later.
- Reset mid-operation: reset in cycle 8 of a multiply -> next cycle busy = done = 0 and results = 0x0000. No `done` appears within the following 20 cycles without a new start.

Source files
------------

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_unit_if : request/response bundle for the multiply/divide  |
// | unit. Rev 1.0                                                      |
// +--------------------------------------------------------------------+
interface muldiv_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_unit : multi-cycle signed multiply (shift-add) and divide  |
// | (restoring) on operand magnitudes with a final sign fix-up.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  wire logic     clk,
  input  wire logic     reset,
  muldiv_unit_if.slave  bus
);

  localparam int c_CNT_W = $clog2(WIDTH);
  localparam int c_DW    = 2 * WIDTH;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [c_DW-1:0]    r_acc;   // product accumulator / partial remainder
  logic [c_DW-1:0]    r_sh;    // shifted multiplicand / dividend-quotient shifter
  logic [WIDTH:0]     r_m;     // multiplier / divisor magnitude
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;

  logic               w_accept;
  logic               w_b_zero;
  logic [WIDTH:0]     w_a_ext;
  logic [WIDTH:0]     w_b_ext;
  logic [WIDTH:0]     w_a_mag;
  logic [WIDTH:0]     w_b_mag;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH+1:0]   w_trial;
  logic               w_fits;
  logic [c_DW-1:0]    w_mul_sum;
  logic               w_neg_q;
  logic [c_DW-1:0]    w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_b_zero = (bus.b == '0);

  // One extra bit so that the magnitude of the most negative value is exact.
  assign w_a_ext = {bus.a[WIDTH-1], bus.a};
  assign w_b_ext = {bus.b[WIDTH-1], bus.b};
  assign w_a_mag = bus.a[WIDTH-1] ? -w_a_ext : w_a_ext;
  assign w_b_mag = bus.b[WIDTH-1] ? -w_b_ext : w_b_ext;

  assign w_rem_sh  = {r_acc[WIDTH-1:0], r_sh[WIDTH-1]};
  assign w_trial   = {1'b0, w_rem_sh} - {1'b0, r_m};
  assign w_fits    = ~w_trial[WIDTH+1];
  assign w_mul_sum = r_acc + (r_m[0] ? r_sh : '0);

  assign w_neg_q = r_sign_a ^ r_sign_b;
  assign w_prod  = w_neg_q ? -r_acc : r_acc;
  assign w_quo   = w_neg_q ? -r_sh[WIDTH-1:0] : r_sh[WIDTH-1:0];
  assign w_rem   = r_sign_a ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_acc    <= '0;
      r_sh     <= '0;
      r_m      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_op     <= bus.op;
            r_sign_a <= bus.a[WIDTH-1];
            r_sign_b <= bus.b[WIDTH-1];
            r_cnt    <= '0;
            r_acc    <= '0;
            r_sh     <= {{(WIDTH-1){1'b0}}, w_a_mag};
            r_m      <= w_b_mag;
            if (bus.op && w_b_zero) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_dbz   <= 1'b1;
              r_lo    <= '0;
              r_hi    <= bus.a;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_dbz   <= 1'b0;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end

        S_RUN: begin
          if (r_op) begin
            r_acc[WIDTH:0]  <= w_fits ? w_trial[WIDTH:0] : w_rem_sh;
            r_sh[WIDTH-1:0] <= {r_sh[WIDTH-2:0], w_fits};
          end else begin
            r_acc <= w_mul_sum;
            r_sh  <= r_sh << 1;
            r_m   <= r_m >> 1;
          end
          r_cnt <= r_cnt + c_CNT_W'(1);
          if (r_cnt == c_LAST) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          if (r_op) begin
            r_lo <= w_quo;
            r_hi <= w_rem;
          end else begin
            r_lo <= w_prod[WIDTH-1:0];
            r_hi <= w_prod[c_DW-1:WIDTH];
          end
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result_lo   = r_lo;
  assign bus.result_hi   = r_hi;
  assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_muldiv_unit : randomized and directed bench for muldiv_unit    |
// | against an arithmetic reference model. Rev 1.0                    |
// +--------------------------------------------------------------------+
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  muldiv_unit_if #(.WIDTH(16)) bus ();

  muldiv_unit #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {div_by_zero, hi, lo} from plain signed arithmetic.
  function automatic logic [32:0] model(input logic op_i, input logic [15:0] a_i, input logic [15:0] b_i);
    int sa;
    int sb;
    int q;
    int r;
    sa = int'($signed(a_i));
    sb = int'($signed(b_i));
    if (!op_i) return {1'b0, 32'(sa * sb)};
    if (sb == 0) return {1'b1, a_i, 16'h0000};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, 16'(r), 16'(q)};
  endfunction

  // Pulses start in the current cycle, returns in the done cycle (cyc = -1 on timeout).
  task automatic run_op(input logic op_i, input logic [15:0] a_i, input logic [15:0] b_i, output int cyc);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    tick();
    bus.start = 1'b0;
    bus.op    = 1'($urandom);
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      if (bus.done) begin
        cyc = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_vec++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
    n_vec++; if ({bus.result_hi, bus.result_lo} !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 00000000", {bus.result_hi, bus.result_lo}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mul_timing();
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'h0003; bus.b = 16'hFFFE;
    for (int k = 1; k <= 18; k++) begin
      tick();
      bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
      n_vec++; if (bus.busy !== (k <= 17)) begin n_err++; $display("FAIL mul_busy c%0d: got %b want %b", k, bus.busy, (k <= 17)); end
      n_vec++; if (bus.done !== (k == 18)) begin n_err++; $display("FAIL mul_done c%0d: got %b want %b", k, bus.done, (k == 18)); end
    end
    n_vec++; if (bus.result_lo !== 16'hFFFA) begin n_err++; $display("FAIL mul_lo: got %h want fffa", bus.result_lo); end
    n_vec++; if (bus.result_hi !== 16'hFFFF) begin n_err++; $display("FAIL mul_hi: got %h want ffff", bus.result_hi); end
    tick();
  endtask

  task automatic test_directed();
    logic        op_t [5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] a_t  [5]  = '{16'h0007, 16'hFFF9, 16'hFFF9, 16'h8000, 16'h8000};
    logic [15:0] b_t  [5]  = '{16'hFFFE, 16'h0002, 16'hFFFE, 16'h8000, 16'hFFFF};
    logic [15:0] lo_t [5]  = '{16'hFFFD, 16'hFFFD, 16'h0003, 16'h0000, 16'h8000};
    logic [15:0] hi_t [5]  = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h4000, 16'h0000};
    int cyc;
    for (int i = 0; i < 5; i++) begin
      run_op(op_t[i], a_t[i], b_t[i], cyc);
      n_vec++; if (cyc !== 18) begin n_err++; $display("FAIL dir%0d_latency: got %0d want 18", i, cyc); end
      n_vec++; if (bus.result_lo !== lo_t[i]) begin n_err++; $display("FAIL dir%0d_lo: got %h want %h", i, bus.result_lo, lo_t[i]); end
      n_vec++; if (bus.result_hi !== hi_t[i]) begin n_err++; $display("FAIL dir%0d_hi: got %h want %h", i, bus.result_hi, hi_t[i]); end
      n_vec++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL dir%0d_dbz: got %b want 0", i, bus.div_by_zero); end
    end
    tick();
  endtask

  task automatic test_div_by_zero();
    int cyc;
    run_op(1'b1, 16'h0012, 16'h0000, cyc);
    n_vec++; if (cyc !== 1) begin n_err++; $display("FAIL dbz_latency: got %0d want 1", cyc); end
    n_vec++; if (bus.div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_flag: got %b want 1", bus.div_by_zero); end
    n_vec++; if ({bus.result_hi, bus.result_lo} !== 32'h0012_0000) begin n_err++; $display("FAIL dbz_result: got %h want 00120000", {bus.result_hi, bus.result_lo}); end
    tick();
    tick();
    n_vec++; if (bus.div_by_zero !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL dbz_hold: got dbz=%b busy=%b want 1/0", bus.div_by_zero, bus.busy); end
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'd2; bus.b = 16'd3;
    tick();
    bus.start = 1'b0;
    n_vec++; if (bus.div_by_zero !== 1'b0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL dbz_clear: got dbz=%b busy=%b want 0/1", bus.div_by_zero, bus.busy); end
    n_vec++; if (bus.result_hi !== 16'h0012) begin n_err++; $display("FAIL dbz_result_held: got %h want 0012", bus.result_hi); end
    for (int k = 0; k < 40 && !bus.done; k++) tick();
    n_vec++; if (bus.result_lo !== 16'd6) begin n_err++; $display("FAIL dbz_next_lo: got %h want 0006", bus.result_lo); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    int cyc;
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'd3; bus.b = 16'd5;
    for (int k = 1; k <= 18; k++) begin
      tick();
      bus.start = (k == 5);
      if (k == 5) begin bus.op = 1'b0; bus.a = 16'd9; bus.b = 16'd9; end
      if (bus.done) n_done++;
    end
    n_vec++; if (n_done !== 1 || bus.done !== 1'b1) begin n_err++; $display("FAIL busy_start_done: got %0d pulses done=%b want 1 at c18", n_done, bus.done); end
    n_vec++; if (bus.result_lo !== 16'h000F) begin n_err++; $display("FAIL busy_start_lo: got %h want 000f", bus.result_lo); end
    run_op(1'b0, 16'd4, 16'hFFFB, cyc);
    n_vec++; if (cyc !== 18) begin n_err++; $display("FAIL b2b_latency: got %0d want 18", cyc); end
    n_vec++; if ({bus.result_hi, bus.result_lo} !== 32'hFFFF_FFEC) begin n_err++; $display("FAIL b2b_result: got %h want ffffffec", {bus.result_hi, bus.result_lo}); end
  endtask

  task automatic test_random();
    logic        op_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [32:0] exp;
    int          cyc;
    for (int i = 0; i < 48; i++) begin
      op_r = 1'($urandom);
      a_r  = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      case ($urandom_range(0, 9))
        0: b_r = 16'h0000;
        1: b_r = 16'hFFFF;
        2: b_r = 16'($urandom_range(0, 15)) | {16{1'($urandom)}} & 16'hFFF8;
        default: b_r = 16'($urandom);
      endcase
      exp = model(op_r, a_r, b_r);
      run_op(op_r, a_r, b_r, cyc);
      n_vec++;
      if (cyc !== (exp[32] ? 1 : 18) || bus.div_by_zero !== exp[32] ||
          {bus.result_hi, bus.result_lo} !== exp[31:0]) begin
        n_err++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: got cyc=%0d dbz=%b res=%h want cyc=%0d dbz=%b res=%h",
                 i, op_r, a_r, b_r, cyc, bus.div_by_zero, {bus.result_hi, bus.result_lo},
                 exp[32] ? 1 : 18, exp[32], exp[31:0]);
      end
      if ($urandom_range(0, 2) == 0) tick();
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    int n_done = 0;
    run_op(1'b0, 16'd7, 16'd9, cyc);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'h1234; bus.b = 16'h0567;
    tick();
    bus.start = 1'b0;
    for (int k = 2; k <= 8; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL midrst_ctrl: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
    n_vec++; if ({bus.result_hi, bus.result_lo} !== 32'h0) begin n_err++; $display("FAIL midrst_result: got %h want 00000000", {bus.result_hi, bus.result_lo}); end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.done) n_done++;
    end
    n_vec++; if (n_done !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses want 0", n_done); end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_mul_timing();
    test_directed();
    test_div_by_zero();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
